// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL phase scanner and its window error counter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pll_ctrl_pkg;

    localparam int PHASE_W   = 8;
    localparam int LEN_W     = PHASE_W + 1;
    localparam int ERR_W_DEF = 16;

    // Error value recorded for a phase whose lock never arrived.
    localparam logic [ERR_W_DEF-1:0] ERR_SAT_DEF = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE,
        ST_MEASURE,
        ST_EVAL,
        ST_APPLY,
        ST_DONE
    } state_t;

    // What the current update/settle sequence belongs to.
    typedef enum logic [1:0] {
        MODE_SCAN,
        MODE_MAN,
        MODE_APPLY
    } mode_t;

    // An error-free run of phases: first phase visited and number of phases.
    typedef struct packed {
        logic [PHASE_W-1:0] start;
        logic [LEN_W-1:0]   len;
    } run_t;

    // Result of a completed sweep.
    typedef struct packed {
        logic [PHASE_W-1:0] phase;
        logic               valid;
    } scan_result_t;

    // Centre of a run, rounding down when the run length is even.
    function automatic logic [PHASE_W-1:0] run_centre(
        input logic [PHASE_W-1:0] start,
        input logic [LEN_W-1:0]   len,
        input logic [PHASE_W-1:0] step
    );
        logic [LEN_W-1:0]         half;
        logic [LEN_W+PHASE_W-1:0] off;
        half = (len - 1'b1) >> 1;
        off  = half * step;
        return start + off[PHASE_W-1:0];
    endfunction

endpackage

// File: rtl/window_err_counter.sv
// Counts err_pulse over a fixed window of WINDOW_CYCLES cycles, saturating at all-ones.
// Latency: window opens the cycle after start; done pulses the cycle after the last window cycle.
// Backpressure: none; start while running restarts the window, clear drops it immediately.
module window_err_counter #(
    parameter int WINDOW_CYCLES = 65536,
    parameter int ERR_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             start,
    input  logic             err_pulse,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int               WIN_W    = $clog2(WINDOW_CYCLES + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_SAT  = '1;

    logic             running;
    logic [WIN_W-1:0] win_cnt;

    // Window timer and saturating error accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running <= 1'b0;
            win_cnt <= '0;
            err_cnt <= '0;
            done    <= 1'b0;
        end else if (clear) begin
            running <= 1'b0;
            win_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                running <= 1'b1;
                win_cnt <= '0;
                err_cnt <= '0;
            end else if (running) begin
                if (err_pulse && (err_cnt != ERR_SAT)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (win_cnt == WIN_LAST) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    win_cnt <= win_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pll_phase_scanner.sv
// Sweeps PLL phase, scores each by error count, programs the centre of the longest clean run.
// Latency: one update per phase plus settle/lock/window time; scan_done marks the settled result.
// Backpressure: scan_start/man_update only taken in IDLE; man_update otherwise gets man_reject.
module pll_phase_scanner
    import pll_ctrl_pkg::*;
#(
    parameter logic [PHASE_W-1:0] PHASE_MAX     = 8'd63,
    parameter logic [PHASE_W-1:0] PHASE_STEP    = 8'd1,
    parameter int                 SETTLE_CYCLES = 65536,
    parameter int                 WINDOW_CYCLES = 65536,
    parameter int                 ERR_W         = ERR_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               scan_start,
    input  logic               scan_abort,
    input  logic               man_update,
    input  logic [PHASE_W-1:0] man_phase,
    input  logic               man_clksrc,
    input  logic               pll_locked,
    input  logic               err_pulse,
    output logic               update,
    output logic [PHASE_W-1:0] pll_phase,
    output logic               pll_clksrc,
    output logic               busy,
    output logic               scan_done,
    output logic [PHASE_W-1:0] best_phase,
    output logic               best_valid,
    output logic               man_reject
);

    localparam int               CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_SAT     = '1;

    state_t             state;
    mode_t              mode;
    logic [PHASE_W-1:0] cur;
    logic               clk_sel;
    logic [CNT_W-1:0]   settle_cnt;
    logic               lock_wait;
    logic [CNT_W-1:0]   guard_cnt;
    logic [ERR_W-1:0]   phase_err;
    logic [ERR_W-1:0]   min_err;
    logic [PHASE_W-1:0] min_phase;
    run_t               run;
    run_t               best_run;
    scan_result_t       pend;

    logic               win_start;
    logic               win_clear;
    logic               win_done;
    logic [ERR_W-1:0]   win_err;

    run_t               run_nxt;
    run_t               best_nxt;
    logic               min_take;
    logic [PHASE_W:0]   next_cur;
    scan_result_t       apply_res;

    assign busy      = (state != ST_IDLE);
    assign win_clear = busy && scan_abort;

    window_err_counter #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .ERR_W         (ERR_W)
    ) u_win (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (win_clear),
        .start     (win_start),
        .err_pulse (err_pulse),
        .done      (win_done),
        .err_cnt   (win_err)
    );

    // Run/min bookkeeping for the phase being evaluated, and the final pick.
    always_comb begin
        run_nxt  = run;
        best_nxt = best_run;
        if (phase_err == '0) begin
            if (run.len == '0) begin
                run_nxt.start = cur;
            end
            run_nxt.len = run.len + 1'b1;
            // Strictly longer only, so the earliest of equal runs survives.
            if (run_nxt.len > best_run.len) begin
                best_nxt = run_nxt;
            end
        end else begin
            run_nxt.len = '0;
        end

        // The sweep always starts at phase 0, which seeds the minimum.
        min_take = (cur == '0) || (phase_err < min_err);
        next_cur = {1'b0, cur} + {1'b0, PHASE_STEP};

        if (best_run.len != '0) begin
            apply_res.phase = run_centre(best_run.start, best_run.len, PHASE_STEP);
            apply_res.valid = 1'b1;
        end else begin
            apply_res.phase = min_phase;
            apply_res.valid = 1'b0;
        end
    end

    // Sequencer: update issue, settle/lock wait, measurement, evaluation and result apply.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            mode       <= MODE_SCAN;
            cur        <= '0;
            clk_sel    <= 1'b0;
            settle_cnt <= '0;
            lock_wait  <= 1'b0;
            guard_cnt  <= '0;
            phase_err  <= '0;
            min_err    <= '0;
            min_phase  <= '0;
            run        <= '0;
            best_run   <= '0;
            pend       <= '0;
            win_start  <= 1'b0;
            update     <= 1'b0;
            pll_phase  <= '0;
            pll_clksrc <= 1'b0;
            scan_done  <= 1'b0;
            best_phase <= '0;
            best_valid <= 1'b0;
            man_reject <= 1'b0;
        end else begin
            update     <= 1'b0;
            scan_done  <= 1'b0;
            man_reject <= 1'b0;
            win_start  <= 1'b0;

            // Spacing guard: a new update may not follow the last within SETTLE_CYCLES.
            if (guard_cnt != '0) begin
                guard_cnt <= guard_cnt - 1'b1;
            end

            if (man_update && (busy || scan_start)) begin
                man_reject <= 1'b1;
            end

            if (busy && scan_abort) begin
                state      <= ST_IDLE;
                lock_wait  <= 1'b0;
                settle_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (scan_start) begin
                            cur      <= '0;
                            clk_sel  <= pll_clksrc;
                            run      <= '0;
                            best_run <= '0;
                            min_err  <= '0;
                            min_phase <= '0;
                            mode     <= MODE_SCAN;
                            state    <= ST_ISSUE;
                        end else if (man_update) begin
                            cur     <= man_phase;
                            clk_sel <= man_clksrc;
                            mode    <= MODE_MAN;
                            state   <= ST_ISSUE;
                        end
                    end

                    ST_ISSUE: begin
                        if (guard_cnt == '0) begin
                            update     <= 1'b1;
                            pll_phase  <= cur;
                            pll_clksrc <= clk_sel;
                            guard_cnt  <= SETTLE_LOAD;
                            settle_cnt <= '0;
                            lock_wait  <= 1'b0;
                            state      <= ST_SETTLE;
                        end
                    end

                    ST_SETTLE: begin
                        if (!lock_wait) begin
                            if (settle_cnt == SETTLE_LAST) begin
                                settle_cnt <= '0;
                                lock_wait  <= 1'b1;
                            end else begin
                                settle_cnt <= settle_cnt + 1'b1;
                            end
                        end else if (pll_locked || (settle_cnt == SETTLE_LAST)) begin
                            lock_wait  <= 1'b0;
                            settle_cnt <= '0;
                            case (mode)
                                MODE_MAN: state <= ST_IDLE;
                                MODE_APPLY: begin
                                    best_phase <= pend.phase;
                                    best_valid <= pend.valid;
                                    scan_done  <= 1'b1;
                                    state      <= ST_DONE;
                                end
                                default: begin
                                    if (pll_locked) begin
                                        win_start <= 1'b1;
                                        state     <= ST_MEASURE;
                                    end else begin
                                        phase_err <= ERR_SAT;
                                        state     <= ST_EVAL;
                                    end
                                end
                            endcase
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end

                    ST_MEASURE: begin
                        if (win_done) begin
                            phase_err <= win_err;
                            state     <= ST_EVAL;
                        end
                    end

                    ST_EVAL: begin
                        run      <= run_nxt;
                        best_run <= best_nxt;
                        if (min_take) begin
                            min_err   <= phase_err;
                            min_phase <= cur;
                        end
                        if (next_cur > {1'b0, PHASE_MAX}) begin
                            state <= ST_APPLY;
                        end else begin
                            cur   <= next_cur[PHASE_W-1:0];
                            state <= ST_ISSUE;
                        end
                    end

                    ST_APPLY: begin
                        pend  <= apply_res;
                        cur   <= apply_res.phase;
                        mode  <= MODE_APPLY;
                        state <= ST_ISSUE;
                    end

                    ST_DONE: begin
                        state <= ST_IDLE;
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
